// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add controller. It shares one external 1-bit
//                full-adder cell across the bits of a WIDTH-bit addition,
//                feeding the cell one bit per clock, LSB first.
//                Result: {c_out, sum_out} = a_in + b_in + c_in.
//  Ports       : clk, rst_n (async, active-low)
//                start, a_in, b_in, c_in   - request and operands
//                fa_a, fa_b, fa_cin        - drive to the FA cell
//                fa_sum, fa_cout           - return from the FA cell
//                busy, done                - status (RUN / one-cycle done)
//                sum_out, c_out            - held result
//                ovf                       - signed overflow, present only
//                                            when SERIAL_ADD_OVF_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] a_sr_q,    a_sr_d;
    logic [WIDTH-1:0] b_sr_q,    b_sr_d;
    logic [WIDTH-1:0] sum_sr_q,  sum_sr_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             c_out_q,   c_out_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q,     ovf_d;
`endif

    logic w_run;
    assign w_run = (state_q == S_RUN);

    // Cell inputs come straight from registers, gated to zero outside RUN.
    assign fa_a    = w_run & a_sr_q[0];
    assign fa_b    = w_run & b_sr_q[0];
    assign fa_cin  = w_run & carry_q;

    assign busy    = w_run;
    assign done    = (state_q == S_DONE);
    assign sum_out = sum_out_q;
    assign c_out   = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf     = ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        sum_out_d = sum_out_q;
        c_out_d   = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                if (cnt_q == c_cnt_last) begin
                    // MSB step: publish the completed word directly from the
                    // shift-in value so sum_out never shows partial bits.
                    state_d   = S_DONE;
                    sum_out_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    c_out_d   = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    // Carry into the MSB differing from carry out of it.
                    ovf_d     = fa_cin ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            sum_out_q <= '0;
            c_out_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            sum_out_q <= sum_out_d;
            c_out_q   <= c_out_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=8) with a
//                behavioural full-adder cell and an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         busy, done, c_out;
    logic [W-1:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    // External full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   64'(busy),    64'd0);
        check({tag, "_done"},   64'(done),    64'd0);
        check({tag, "_sum"},    64'(sum_out), 64'd0);
        check({tag, "_cout"},   64'(c_out),   64'd0);
        check({tag, "_fa_a"},   64'(fa_a),    64'd0);
        check({tag, "_fa_b"},   64'(fa_b),    64'd0);
        check({tag, "_fa_cin"}, 64'(fa_cin),  64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"},    64'(ovf),     64'd0);
`endif
    endtask

    // Caller is positioned 1 time unit after a rising edge, DUT in IDLE.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0]      res;
        logic            ov;
        longint unsigned la, lb, m, cexp;
        res = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        ov  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        la  = a;
        lb  = b;
        start = 1'b1; a_in = a; b_in = b; c_in = ci;
        @(posedge clk); #1;
        // Operand wiggles after capture must not matter.
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            m    = (64'd1 << i) - 64'd1;
            cexp = ((la & m) + (lb & m) + 64'(ci)) >> i;
            check("run_busy",   64'(busy),    64'd1);
            check("run_done",   64'(done),    64'd0);
            check("fa_cin",     64'(fa_cin),  cexp & 64'd1);
            check("fa_a",       64'(fa_a),    (la >> i) & 64'd1);
            check("fa_b",       64'(fa_b),    (lb >> i) & 64'd1);
            check("sum_hold",   64'(sum_out), 64'(exp_sum));
            @(posedge clk); #1;
        end
        exp_sum  = res[W-1:0];
        exp_cout = res[W];
        exp_ovf  = ov;
        check("done_pulse", 64'(done),    64'd1);
        check("done_busy",  64'(busy),    64'd0);
        check("sum_out",    64'(sum_out), 64'(exp_sum));
        check("c_out",      64'(c_out),   64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf",        64'(ovf),     64'(exp_ovf));
`endif
        @(posedge clk); #1;
        check("done_clear", 64'(done),    64'd0);
        check("idle_sum",   64'(sum_out), 64'(exp_sum));
    endtask

    initial begin
        int done_cnt;
        int last_done;

        // Power-on reset.
        #1;
        check_reset_outputs("por");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_rel");

        // Directed vectors.
        do_add(8'h5A, 8'h3C, 1'b0);
        // Result held through IDLE.
        for (int i = 0; i < 20; i++) begin
            check("hold_sum",  64'(sum_out), 64'h96);
            check("hold_done", 64'(done),    64'd0);
            @(posedge clk); #1;
        end
        do_add(8'hFF, 8'h01, 1'b0);
        do_add(8'h00, 8'h00, 1'b1);
        do_add(8'h7F, 8'h01, 1'b0);
        do_add(8'h80, 8'h80, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1);

        // Start held high: one add per W+2 cycles, operand change mid-RUN.
        done_cnt  = 0;
        last_done = 0;
        start = 1'b1; a_in = 8'h10; b_in = 8'h20; c_in = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 4) begin
                a_in = 8'hFF;
                b_in = 8'hFF;
            end
            if (done) begin
                if (done_cnt == 0) begin
                    check("held_first_sum",  64'(sum_out), 64'h30);
                    check("held_first_cout", 64'(c_out),   64'd0);
                end else begin
                    check("held_gap",       64'(cyc - last_done), 64'(W + 2));
                    check("held_next_sum",  64'(sum_out), 64'hFE);
                    check("held_next_cout", 64'(c_out),   64'd1);
                end
                done_cnt++;
                last_done = cyc;
            end
        end
        check("held_done_count", 64'(done_cnt), 64'd4);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_idle");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;

        // Asynchronous reset in RUN cycle 4.
        start = 1'b1; a_in = 8'h5A; b_in = 8'h3C; c_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_sum_kept_zero", 64'(sum_out), 64'd0);
        do_add(8'h01, 8'h01, 1'b0);
        check("post_rst_sum", 64'(sum_out), 64'h02);

        // Randomized operands against the arithmetic reference.
        for (int n = 0; n < 25; n++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
